sistema_pio_bidir: RTL and testbench

SISTEMA_PIO_BIDIR -- requirements
Module: sistema_pio_bidir

---
 rtl/sistema_pio_bidir.sv | 107 ++++++++++
 tb/tb_sistema_pio_bidir.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sistema_pio_bidir.sv
// Bidirectional parallel I/O port with output set/clear, per-bit direction,
// synchronised inputs, edge capture and a masked level interrupt.
module sistema_pio_bidir #(
  parameter int               WIDTH       = 14,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] edge_w;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] rd_w;
  logic             wr_en;

  assign wr_en   = chipselect & ~write_n;
  assign wdata_w = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
    end
  endgenerate

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_w = sync2_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_w = ~sync2_q & prev_q;
    end else begin : g_any
      assign edge_w = sync2_q ^ prev_q;
    end
  endgenerate

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    capture_d  = capture_q;
    if (wr_en) begin
      case (address)
        3'd0: data_out_d = wdata_w;
        3'd1: dir_d      = wdata_w;
        3'd2: mask_d     = wdata_w;
        3'd3: capture_d  = capture_q & ~wdata_w;
        3'd4: data_out_d = data_out_q | wdata_w;
        3'd5: data_out_d = data_out_q & ~wdata_w;
        default: ;
      endcase
    end
    // New edges are OR'd in after the clear so a simultaneous set wins.
    capture_d = capture_d | edge_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= '0;
      mask_q     <= '0;
      capture_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      capture_q  <= capture_d;
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
    end
  end

  always_comb begin
    rd_w = '0;
    case (address)
      3'd0: rd_w = (data_out_q & dir_q) | (sync2_q & ~dir_q);
      3'd1: rd_w = dir_q;
      3'd2: rd_w = mask_q;
      3'd3: rd_w = capture_q;
      default: rd_w = '0;
    endcase
  end

  assign readdata = 32'(rd_w);
  assign out_port = data_out_q;
  assign oe       = dir_q;
  assign irq      = |(capture_q & mask_q);

endmodule

// File: tb/tb_sistema_pio_bidir.sv
// Directed bench: a 14-bit rising-edge port and a 32-bit any-edge port.
module tb_sistema_pio_bidir;

  localparam logic [13:0] RV = 14'h0A5C;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        cs14, cs32, write_n;
  logic [31:0] writedata;
  logic [13:0] in14, out14, oe14;
  logic [31:0] in32, out32, oe32;
  logic [31:0] rd14, rd32;
  logic        irq14, irq32;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  sistema_pio_bidir #(.WIDTH(14), .RESET_VALUE(RV), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs14),
    .write_n(write_n), .writedata(writedata), .in_port(in14),
    .out_port(out14), .oe(oe14), .readdata(rd14), .irq(irq14));

  sistema_pio_bidir #(.WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(2)) dut32 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs32),
    .write_n(write_n), .writedata(writedata), .in_port(in32),
    .out_port(out32), .oe(oe32), .readdata(rd32), .irq(irq32));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input bit sel32, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write_n = 1'b0;
    cs14 = ~sel32; cs32 = sel32;
    @(negedge clk);
    cs14 = 1'b0; cs32 = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input bit sel32, input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = sel32 ? rd32 : rd14;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; address = '0; cs14 = 1'b0; cs32 = 1'b0; write_n = 1'b1;
    writedata = '0; in14 = '0; in32 = '0;
    cyc(3);
    reset = 1'b0;
    cyc(1);

    chk("rst_out_port", 32'(out14), 32'(RV));
    chk("rst_oe", 32'(oe14), 32'h0);
    chk("rst_irq", 32'(irq14), 32'h0);
    rd(0, 3'd1, v); chk("rst_dir_read", v, 32'h0);

    wr(0, 3'd0, 32'hFFFF_3FFF); chk("wr_data", 32'(out14), 32'h3FFF);
    wr(0, 3'd5, 32'h0000_00F0); chk("wr_outclear", 32'(out14), 32'h3F0F);
    wr(0, 3'd4, 32'h0000_0001); chk("wr_outset", 32'(out14), 32'h3F0F);
    wr(0, 3'd4, 32'h0000_0030); chk("wr_outset2", 32'(out14), 32'h3F3F);

    wr(0, 3'd1, 32'h0000_00FF); chk("oe_dir", 32'(oe14), 32'h00FF);
    wr(0, 3'd0, 32'h0000_1234);
    in14 = 14'h3A5A;
    cyc(3);
    rd(0, 3'd0, v); chk("mixed_read", v, 32'h0000_3A34);
    rd(0, 3'd3, v); chk("cap_rise_all", v, 32'h0000_3A5A);
    chk("irq_masked", 32'(irq14), 32'h0);
    wr(0, 3'd3, 32'h0000_3FFF);
    rd(0, 3'd3, v); chk("cap_clear", v, 32'h0);

    wr(0, 3'd6, 32'hFFFF_FFFF);
    wr(0, 3'd7, 32'h0000_0000);
    chk("rsvd_no_effect_data", 32'(out14), 32'h1234);
    rd(0, 3'd1, v); chk("rsvd_no_effect_dir", v, 32'h00FF);
    rd(0, 3'd6, v); chk("rd_addr6", v, 32'h0);
    rd(0, 3'd4, v); chk("rd_addr4", v, 32'h0);

    wr(0, 3'd2, 32'h0000_0004);
    in14 = 14'h3A5E;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("irq_before_n2", 32'(irq14), 32'h0);
    @(negedge clk);
    chk("irq_at_n2", 32'(irq14), 32'h1);
    rd(0, 3'd3, v); chk("cap_bit2", v, 32'h0000_0004);
    wr(0, 3'd3, 32'h0000_0004);
    chk("irq_cleared", 32'(irq14), 32'h0);

    in14 = 14'h3A5A;
    cyc(3);
    rd(0, 3'd3, v); chk("fall_no_capture", v, 32'h0);

    in14 = 14'h3A5E;
    cyc(2);
    address = 3'd3; writedata = 32'h4; write_n = 1'b0; cs14 = 1'b1;
    @(negedge clk);
    cs14 = 1'b0; write_n = 1'b1;
    rd(0, 3'd3, v); chk("set_beats_clear", v, 32'h0000_0004);
    chk("set_beats_clear_irq", 32'(irq14), 32'h1);

    wr(0, 3'd2, 32'h0000_3FFF);
    in14 = 14'h0000;
    cyc(3);
    in14 = 14'h3FFF;
    cyc(3);
    rd(0, 3'd3, v); chk("cap_full", v, 32'h0000_3FFF);
    chk("irq_full", 32'(irq14), 32'h1);

    @(negedge clk);
    reset = 1'b1;
    address = 3'd0; writedata = 32'h1111; write_n = 1'b0; cs14 = 1'b1;
    @(negedge clk);
    reset = 1'b0; cs14 = 1'b0; write_n = 1'b1;
    chk("rst_mid_irq", 32'(irq14), 32'h0);
    chk("rst_mid_out", 32'(out14), 32'(RV));
    rd(0, 3'd3, v); chk("rst_mid_cap", v, 32'h0);
    rd(0, 3'd0, v); chk("rst_mid_sync", v, 32'h0);
    cyc(4);
    rd(0, 3'd3, v); chk("held_high_after_rst", v, 32'h0000_3FFF);
    chk("held_high_irq_unmasked", 32'(irq14), 32'h0);

    in32 = 32'h8000_0000;
    cyc(3);
    rd(1, 3'd3, v); chk("w32_toggle_up", v, 32'h8000_0000);
    wr(1, 3'd3, 32'h8000_0000);
    rd(1, 3'd3, v); chk("w32_clear", v, 32'h0);
    in32 = 32'h0000_0000;
    cyc(3);
    rd(1, 3'd3, v); chk("w32_toggle_down", v, 32'h8000_0000);
    rd(1, 3'd6, v); chk("w32_addr6", v, 32'h0);
    rd(1, 3'd7, v); chk("w32_addr7", v, 32'h0);
    wr(1, 3'd1, 32'hFFFF_FFFF);
    wr(1, 3'd0, 32'hDEAD_BEEF);
    rd(1, 3'd0, v); chk("w32_data_read", v, 32'hDEAD_BEEF);
    chk("w32_oe", oe32, 32'hFFFF_FFFF);
    rd(0, 3'd1, v); chk("w14_untouched_dir", v, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
